passage_arbiter: RTL and testbench
==================================

Name: passage_arbiter

Overview:
- Controller that shares the single passageway door between N requesting agents and sequences one crossing at a time: grant, open door, doorstep, zone 0->1->2, close.
- Drives the door/doorstep/zone/fault signals consumed by the passageway monitor.
- Holds sticky error/fault flags for the test harness.

Parameters:
N_REQ, 2, number of requesting agents (2..8)
OPEN_CYCLES, 3, cycles the door spends opening before an agent may step in (>=1)
TIMEOUT, 16, max cycles without progress in WAIT_DS or CROSS before fault (>=2)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-agent passage request, level, held until done
iup  input  1  granted agent moves up (0 = down)
iright  input  1  granted agent moves right (0 = left)
grant  output  N_REQ  one-hot grant, registered
door_open  output  1  door open
doorstep  output  1  granted agent stands at doorstep
zone  output  2  granted agent zone, 0..2
done  output  1  one-cycle pulse when a crossing completes
busy  output  1  state != IDLE
error  output  1  sticky protocol error
fault  output  1  sticky timeout fault

Behaviour:
- Reset: state IDLE, grant=0, door_open=0, doorstep=0, zone=0, done=0, error=0, fault=0, rr_ptr=0, counters=0. rst mid-crossing aborts immediately, with no done pulse.
- All outputs are registered. Each transition takes effect on the next clk edge.
- IDLE:
  - If any req is set, grant the first set bit at or after rr_ptr (wrapping modulo N_REQ) and go to OPEN.
  - With no req, stay in IDLE.
- OPEN:
  - door_open=1 and settle counter runs.
  - After OPEN_CYCLES cycles in OPEN, go to WAIT_DS.
  - iup=1 while in OPEN sets error and goes to FAULT.
- WAIT_DS:
  - iright=1 sets doorstep=1, zone=0 and goes to CROSS.
  - Otherwise the progress counter increments. When it reaches TIMEOUT, set fault and go to FAULT.
- CROSS:
  - Doorstep held. iright=1 and iup=1 advances zone by 1 and clears the progress counter.
  - When zone becomes 2, go to CLOSE.
  - iright=0 (left from doorstep) sets error and goes to FAULT.
  - iright=1 and iup=0: hold, progress counter increments, timeout as in WAIT_DS.
- CLOSE (one cycle): door_open=0, doorstep=0, zone=0, grant=0, done=1 if zone reached 2. rr_ptr = granted index + 1 (mod N_REQ). Go to IDLE.
- Abort: the granted req dropping in OPEN, WAIT_DS or CROSS goes to CLOSE with done=0. rr_ptr still advances.
- FAULT: door_open=0, doorstep=0, grant=0. Absorbing; only rst exits. error and fault are never cleared except by rst.
- Simultaneous events:
  - Timeout and error in the same cycle: both flags set.
  - Abort and zone==2 in the same cycle: completion wins, done=1.
- req changes of non-granted agents are ignored until IDLE.
- Counters are $clog2(TIMEOUT+1) bits wide and saturate. zone never exceeds 2.

Optional Feature:
PASSAGE_URGENT_EN
- Defined: in IDLE, req[0] wins over the round-robin pointer. rr_ptr updates only on non-zero grants.
- Undefined: pure round-robin across all agents.

Decomposition:
- Package passage_pkg:
  - state enum: IDLE, OPEN, WAIT_DS, CROSS, CLOSE, FAULT.
  - zone constants: ZONE0=0, ZONE1=1, ZONE2=2.
  - width helper function.
- Sub-module rr_picker: combinational round-robin one-hot picker with req, rr_ptr in and one-hot grant out, parameterized by N_REQ. Instantiated once.

Test Plan:
- req=2'b11 from reset, iright=1, iup=1 after OPEN -> grant=01; door_open 3 cycles; zone 0->1->2; done pulse; then grant=10 on the next crossing.
- Granted agent with iright=0 for 16 cycles in WAIT_DS -> fault=1 on cycle 16, door_open=0, state stays FAULT until rst.
- In CROSS with zone=1, drive iright=0 -> error=1, grant=0, door closed; rst -> all outputs 0.
- Drop req[1] while granted in CROSS at zone=1 -> CLOSE with done=0, grant=0 next cycle, rr_ptr=0.
- Assert rst in OPEN -> next cycle all outputs 0, busy=0; no done pulse.
- With PASSAGE_URGENT_EN, rr_ptr=0 after agent 0 completes, req=2'b11 -> grant=01 again; without the macro -> grant=10.

Source files
------------

// File: rtl/passage_pkg.sv
// passage_pkg: shared types and helpers for the passageway arbiter.
//   state_t   - arbiter FSM states
//   zone_t    - zone index of the crossing agent (ZONE0..ZONE2)
//   width_for - bits needed to hold values 0..max_value (at least 1)
package passage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    WAIT_DS,
    CROSS,
    CLOSE,
    FAULT
  } state_t;

  typedef logic [1:0] zone_t;

  localparam zone_t ZONE0 = 2'd0;
  localparam zone_t ZONE1 = 2'd1;
  localparam zone_t ZONE2 = 2'd2;

  function automatic int width_for(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/passage_arbiter_if.sv
// passage_arbiter_if: agent-side bundle of the passageway arbiter.
//   req      agents -> arbiter  per-agent level request, held until done
//   iup      agents -> arbiter  granted agent moves up (0 = down)
//   iright   agents -> arbiter  granted agent moves right (0 = left)
//   grant    arbiter -> agents  one-hot grant
//   door_open, doorstep, zone   door / agent position for the monitor
//   done     one-cycle pulse on a completed crossing
//   busy     arbiter not idle
//   error, fault                sticky protocol error / timeout fault
// master = agents/harness side, slave = arbiter side.
interface passage_arbiter_if
  import passage_pkg::*;
#(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0] req;
  logic             iup;
  logic             iright;
  logic [N_REQ-1:0] grant;
  logic             door_open;
  logic             doorstep;
  zone_t            zone;
  logic             done;
  logic             busy;
  logic             error;
  logic             fault;

  modport master (
    output req, iup, iright,
    input  grant, door_open, doorstep, zone, done, busy, error, fault
  );

  modport slave (
    input  req, iup, iright,
    output grant, door_open, doorstep, zone, done, busy, error, fault
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req    - request vector
//   rr_ptr - index with the highest priority this round (< N_REQ)
//   grant  - one-hot: first set req bit at or after rr_ptr, wrapping
module rr_picker
  import passage_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = width_for(N_REQ - 1)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] req_hi;

  // Requests at or above the pointer are served first; otherwise wrap
  // around and take the lowest request overall. x & -x isolates the
  // lowest set bit.
  // NOTE: every output of an always_comb is assigned on every path so no
  // latch is inferred.
  always_comb begin
    hi_mask = {N_REQ{1'b1}} << rr_ptr;
    req_hi  = req & hi_mask;
    if (req_hi != '0) grant = req_hi & (~req_hi + 1'b1);
    else              grant = req & (~req + 1'b1);
  end

endmodule

// File: rtl/passage_arbiter.sv
// passage_arbiter: shares the passageway door between N_REQ agents and
// sequences one crossing at a time: grant, open, doorstep, zone 0->1->2,
// close. All outputs are registered.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - passage_arbiter_if.slave (req/iup/iright in; grant, door_open,
//          doorstep, zone, done, busy, error, fault out)
// Optional build macro PASSAGE_URGENT_EN: req[0] beats the round-robin
// pointer in IDLE, and the pointer only moves after non-zero grants.
// The interface instance must be built with the same N_REQ.
module passage_arbiter
  import passage_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int OPEN_CYCLES = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  passage_arbiter_if.slave  bus
);

  localparam int IW = width_for(N_REQ - 1);
  // One counter serves as settle counter in OPEN and progress counter in
  // WAIT_DS/CROSS; OPEN_CYCLES is expected to be <= TIMEOUT.
  localparam int CW = width_for(TIMEOUT);

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, gidx, ptr_next;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0] pick, idle_grant, grant_q, grant_d;
  logic             door_q, door_d, ds_q, ds_d;
  zone_t            zone_q, zone_d;
  logic             done_q, done_d, busy_q;
  logic             error_q, error_d, fault_q, fault_d;
  logic             req_held, adv, tmo_hit;
  logic             fin_ev, abort_ev, err_ev, tmo_ev;

  rr_picker #(.N_REQ(N_REQ), .PW(IW)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick)
  );

`ifdef PASSAGE_URGENT_EN
  assign idle_grant = bus.req[0] ? N_REQ'(1) : pick;
`else
  assign idle_grant = pick;
`endif

  // Index of the current one-hot grant, for the pointer update.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (((grant_q >> i) & N_REQ'(1)) != '0) gidx = IW'(i);
  end

  assign ptr_next = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  assign req_held = |(bus.req & grant_q);
  assign adv      = bus.iright & bus.iup;
  assign cnt_inc  = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit  = (cnt_inc == CW'(TIMEOUT));

  // Next-state logic plus the events that drive the sticky flags.
  // Completion outranks abort; abort outranks error/timeout since an agent
  // that has dropped its request no longer drives meaningful moves.
  always_comb begin
    state_d  = state_q;
    fin_ev   = 1'b0;
    abort_ev = 1'b0;
    err_ev   = 1'b0;
    tmo_ev   = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) state_d = OPEN;
      OPEN: begin
        abort_ev = !req_held;
        err_ev   = req_held & bus.iup;
        if (!abort_ev && !err_ev && cnt_q == CW'(OPEN_CYCLES - 1))
          state_d = WAIT_DS;
      end
      WAIT_DS: begin
        abort_ev = !req_held;
        tmo_ev   = req_held & !bus.iright & tmo_hit;
        if (req_held && bus.iright) state_d = CROSS;
      end
      CROSS: begin
        fin_ev   = adv && (zone_q == ZONE1);
        abort_ev = !fin_ev && !req_held;
        err_ev   = !fin_ev && req_held && !bus.iright;
        tmo_ev   = !fin_ev && req_held && bus.iright && !bus.iup && tmo_hit;
      end
      CLOSE:   state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (fin_ev || abort_ev)   state_d = CLOSE;
    else if (err_ev || tmo_ev) state_d = FAULT;
  end

  // Next values of the registered outputs, counter and pointer.
  always_comb begin
    grant_d  = grant_q;
    door_d   = door_q;
    ds_d     = ds_q;
    zone_d   = zone_q;
    done_d   = 1'b0;
    cnt_d    = '0;
    rr_ptr_d = rr_ptr_q;
    error_d  = error_q | err_ev;
    fault_d  = fault_q | tmo_ev;
    case (state_q)
      IDLE: if (state_d == OPEN) begin
        grant_d = idle_grant;
        door_d  = 1'b1;
      end
      OPEN:    if (state_d == OPEN) cnt_d = cnt_inc;
      WAIT_DS: begin
        if (state_d == WAIT_DS) cnt_d = cnt_inc;
        if (state_d == CROSS) begin
          ds_d   = 1'b1;
          zone_d = ZONE0;
        end
      end
      CROSS: begin
        if (adv && (fin_ev || state_d == CROSS))
          zone_d = (zone_q == ZONE0) ? ZONE1 : ZONE2;
        if (state_d == CROSS && !adv) cnt_d = cnt_inc;
      end
      CLOSE: begin
        grant_d = '0;
        door_d  = 1'b0;
        ds_d    = 1'b0;
        zone_d  = ZONE0;
        done_d  = (zone_q == ZONE2);
`ifdef PASSAGE_URGENT_EN
        if (gidx != '0) rr_ptr_d = ptr_next;
`else
        rr_ptr_d = ptr_next;
`endif
      end
      default: ;
    endcase
    // Faults release the door in the same edge that raises the flag.
    if (state_d == FAULT) begin
      grant_d = '0;
      door_d  = 1'b0;
      ds_d    = 1'b0;
      zone_d  = ZONE0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      door_q   <= 1'b0;
      ds_q     <= 1'b0;
      zone_q   <= ZONE0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      door_q   <= door_d;
      ds_q     <= ds_d;
      zone_q   <= zone_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
      error_q  <= error_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.door_open = door_q;
  assign bus.doorstep  = ds_q;
  assign bus.zone      = zone_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_passage_arbiter.sv
// tb_passage_arbiter: directed vectors for passage_arbiter (N_REQ=2,
// OPEN_CYCLES=3, TIMEOUT=16). Inputs are applied 1 time unit after a
// rising edge; outputs are compared 1 time unit after the next one.
module tb_passage_arbiter;

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic       iup;
    logic       iright;
    logic [1:0] grant;
    logic       door;
    logic       ds;
    logic [1:0] zone;
    logic       done;
    logic       busy;
    logic       err;
    logic       flt;
  } vec_t;

`ifdef PASSAGE_URGENT_EN
  localparam logic [1:0] SECOND = 2'b01;
`else
  localparam logic [1:0] SECOND = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t trace [10];

  passage_arbiter_if #(.N_REQ(2)) bus ();

  passage_arbiter #(.N_REQ(2), .OPEN_CYCLES(3), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [1:0] rq,
                              input logic u, input logic ir,
                              input logic [1:0] g, input logic d,
                              input logic s, input logic [1:0] z,
                              input logic dn, input logic b,
                              input logic e, input logic f);
    return {r, rq, u, ir, g, d, s, z, dn, b, e, f};
  endfunction

  task automatic check(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (grant,door,ds,zone,done,busy,err,flt)",
               name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string name);
    rst        = v.rst;
    bus.req    = v.req;
    bus.iup    = v.iup;
    bus.iright = v.iright;
    @(posedge clk);
    #1;
    check(name,
          {bus.grant, bus.door_open, bus.doorstep, bus.zone,
           bus.done, bus.busy, bus.error, bus.fault},
          {v.grant, v.door, v.ds, v.zone, v.done, v.busy, v.err, v.flt});
  endtask

  // From IDLE: grant, three OPEN cycles, step onto the doorstep, zone 1.
  task automatic cross_to_zone1(input string tag, input logic [1:0] rq,
                                input logic [1:0] g);
    run(mk(0, rq, 0, 0, g, 1, 0, 2'd0, 0, 1, 0, 0), {tag, ".grant"});
    for (int i = 0; i < 3; i++)
      run(mk(0, rq, 0, 1, g, 1, 0, 2'd0, 0, 1, 0, 0), {tag, ".open"});
    run(mk(0, rq, 0, 1, g, 1, 1, 2'd0, 0, 1, 0, 0), {tag, ".doorstep"});
    run(mk(0, rq, 1, 1, g, 1, 1, 2'd1, 0, 1, 0, 0), {tag, ".zone1"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.req    = '0;
    bus.iup    = 1'b0;
    bus.iright = 1'b0;

    // Full crossing by agent 0; iright is high during OPEN so the doorstep
    // appears exactly after the third OPEN cycle.
    trace[0] = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 0);
    trace[1] = mk(0, 2'b11, 0, 0, 2'b01, 1, 0, 2'd0, 0, 1, 0, 0);
    trace[2] = mk(0, 2'b11, 0, 1, 2'b01, 1, 0, 2'd0, 0, 1, 0, 0);
    trace[3] = mk(0, 2'b11, 0, 1, 2'b01, 1, 0, 2'd0, 0, 1, 0, 0);
    trace[4] = mk(0, 2'b11, 0, 1, 2'b01, 1, 0, 2'd0, 0, 1, 0, 0);
    trace[5] = mk(0, 2'b11, 0, 1, 2'b01, 1, 1, 2'd0, 0, 1, 0, 0);
    trace[6] = mk(0, 2'b11, 1, 1, 2'b01, 1, 1, 2'd1, 0, 1, 0, 0);
    trace[7] = mk(0, 2'b11, 1, 1, 2'b01, 1, 1, 2'd2, 0, 1, 0, 0);
    trace[8] = mk(0, 2'b11, 0, 0, 2'b00, 0, 0, 2'd0, 1, 0, 0, 0);
    trace[9] = mk(0, 2'b11, 0, 0, SECOND, 1, 0, 2'd0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      run(trace[i], $sformatf("trace1[%0d]", i));

    // Timeout: three OPEN cycles, then 16 WAIT_DS cycles with no step.
    for (int i = 0; i < 3; i++)
      run(mk(0, 2'b11, 0, 0, SECOND, 1, 0, 2'd0, 0, 1, 0, 0), "tmo.open");
    for (int i = 1; i < 16; i++)
      run(mk(0, 2'b11, 0, 0, SECOND, 1, 0, 2'd0, 0, 1, 0, 0),
          $sformatf("tmo.wait%0d", i));
    run(mk(0, 2'b11, 0, 0, 2'b00, 0, 0, 2'd0, 0, 1, 0, 1), "tmo.fault");
    run(mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 2'd0, 0, 1, 0, 1), "tmo.absorb1");
    run(mk(0, 2'b01, 0, 1, 2'b00, 0, 0, 2'd0, 0, 1, 0, 1), "tmo.absorb2");

    // Stepping left from the doorstep at zone 1 is a protocol error.
    run(mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 0), "err.rst");
    cross_to_zone1("err", 2'b01, 2'b01);
    run(mk(0, 2'b01, 0, 0, 2'b00, 0, 0, 2'd0, 0, 1, 1, 0), "err.left");
    run(mk(0, 2'b01, 0, 1, 2'b00, 0, 0, 2'd0, 0, 1, 1, 0), "err.sticky");
    run(mk(1, 2'b01, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 0), "err.rst_clear");

    // Agent 1 drops its request at zone 1: close without done, pointer 0.
    cross_to_zone1("abort", 2'b10, 2'b10);
    run(mk(0, 2'b00, 0, 1, 2'b10, 1, 1, 2'd1, 0, 1, 0, 0), "abort.close");
    run(mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 0), "abort.idle");

    // Agent 0 reaches zone 2 on the same cycle it drops req: completion wins.
    cross_to_zone1("fin", 2'b11, 2'b01);
    run(mk(0, 2'b00, 1, 1, 2'b01, 1, 1, 2'd2, 0, 1, 0, 0), "fin.close");
    run(mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 2'd0, 1, 0, 0, 0), "fin.done");
    run(mk(0, 2'b11, 0, 0, SECOND, 1, 0, 2'd0, 0, 1, 0, 0), "fin.next_grant");

    // Reset while in OPEN aborts with everything low and no done pulse.
    run(mk(1, 2'b11, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 0), "rst_open");
    run(mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 0), "rst_open.nodone");

    // Moving up while the door is still opening is a protocol error.
    run(mk(0, 2'b01, 0, 0, 2'b01, 1, 0, 2'd0, 0, 1, 0, 0), "open_up.grant");
    run(mk(0, 2'b01, 1, 0, 2'b00, 0, 0, 2'd0, 0, 1, 1, 0), "open_up.error");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
